// File: rtl/fir_stream_driver.sv
// fir_stream_driver
// Buffers upstream signed samples in a small FIFO and sequences one frame into
// an n_tap_fir. The sequence is: coefficient load handshake, sample streaming
// with stall on underflow, an optional zero flush of the tap line, and a
// one-cycle completion pulse.
//
// Build option: define FIR_FLUSH_ZEROS_EN to append LENGTH-1 zeros after every
// frame. Without it, the FLUSH state and its counter do not exist, and the last
// sample goes straight to FINISH.
//
// Output timing: every output except sampleReady is registered. The done and
// stopDataLoadFlag pulse is issued on the edge that leaves FINISH. As a result
// it sits directly behind the last loadDataFlag cycle, and busy stays high
// through it.

module fir_stream_driver #(
    parameter int DATA_WIDTH = 18,
    parameter int LENGTH     = 20,
    parameter int FRAME_LEN  = 60,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] sampleIn,
    input  logic                  sampleValid,
    output logic                  sampleReady,
    output logic                  enableFIRCoeff,
    input  logic                  coeffSetFlag,
    output logic                  loadDataFlag,
    output logic                  stopDataLoadFlag,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic                  busy,
    output logic                  done
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = $clog2(FRAME_LEN + 1);
`ifdef FIR_FLUSH_ZEROS_EN
    localparam int FCW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
`endif

    // Reject configurations the pointer arithmetic and counters cannot handle
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LENGTH < 2 || FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_params
        $error("fir_stream_driver: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_COEFF,
        S_STREAM,
`ifdef FIR_FLUSH_ZEROS_EN
        S_FLUSH,
`endif
        S_FINISH
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_head;

    // Sequencer state and registered outputs
    state_t                state_q, state_d;
    logic [SCW-1:0]        sample_cnt_q, sample_cnt_d;
`ifdef FIR_FLUSH_ZEROS_EN
    logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
`endif
    logic                  enable_coeff_q, enable_coeff_d;
    logic                  load_data_q, load_data_d;
    logic                  stop_load_q, stop_load_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Full and empty come from the registered count. A write into a full FIFO
    // is refused even when a pop happens on the same edge. A write into an
    // empty FIFO cannot be popped on the same edge.
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign sampleReady = !fifo_full;
    assign push        = sampleValid && !fifo_full;
    assign pop         = (state_q == S_STREAM) && !fifo_empty;
    assign fifo_head   = fifo_mem[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sample storage; contents need no reset because the pointers gate all reads
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sampleIn;
        end
    end

    // FIFO pointer and count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
`ifdef FIR_FLUSH_ZEROS_EN
        flush_cnt_d    = flush_cnt_q;
`endif
        enable_coeff_d = enable_coeff_q;
        load_data_d    = 1'b0;
        stop_load_d    = 1'b0;
        done_d         = 1'b0;
        data_in_d      = data_in_q;

        case (state_q)
            S_IDLE: begin
                enable_coeff_d = 1'b0;
                data_in_d      = '0;
                if (start) begin
                    enable_coeff_d = 1'b1;
                    state_d        = S_LOAD_COEFF;
                end
            end

            S_LOAD_COEFF: begin
                enable_coeff_d = 1'b1;
                if (coeffSetFlag) begin
                    enable_coeff_d = 1'b0;
                    state_d        = S_STREAM;
                end
            end

            S_STREAM: begin
                if (pop) begin
                    data_in_d    = fifo_head;
                    load_data_d  = 1'b1;
                    sample_cnt_d = sample_cnt_q + SCW'(1);
                    if (sample_cnt_q == SCW'(FRAME_LEN - 1)) begin
`ifdef FIR_FLUSH_ZEROS_EN
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
`else
                        state_d     = S_FINISH;
`endif
                    end
                end
            end

`ifdef FIR_FLUSH_ZEROS_EN
            S_FLUSH: begin
                data_in_d   = '0;
                load_data_d = 1'b1;
                flush_cnt_d = flush_cnt_q + FCW'(1);
                if (flush_cnt_q == FCW'(LENGTH - 2)) begin
                    state_d = S_FINISH;
                end
            end
`endif

            S_FINISH: begin
                data_in_d    = '0;
                stop_load_d  = 1'b1;
                done_d       = 1'b1;
                sample_cnt_d = '0;
`ifdef FIR_FLUSH_ZEROS_EN
                flush_cnt_d  = '0;
`endif
                state_d      = S_IDLE;
            end

            default: begin
                state_d        = S_IDLE;
                enable_coeff_d = 1'b0;
                data_in_d      = '0;
                sample_cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE) || done_d;
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sample_cnt_q   <= '0;
`ifdef FIR_FLUSH_ZEROS_EN
            flush_cnt_q    <= '0;
`endif
            enable_coeff_q <= 1'b0;
            load_data_q    <= 1'b0;
            stop_load_q    <= 1'b0;
            data_in_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
`ifdef FIR_FLUSH_ZEROS_EN
            flush_cnt_q    <= flush_cnt_d;
`endif
            enable_coeff_q <= enable_coeff_d;
            load_data_q    <= load_data_d;
            stop_load_q    <= stop_load_d;
            data_in_q      <= data_in_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign enableFIRCoeff   = enable_coeff_q;
    assign loadDataFlag     = load_data_q;
    assign stopDataLoadFlag = stop_load_q;
    assign dataIn           = data_in_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
